core_trace_fifo: RTL

//  Downstream observer of the 4-bit core: samples the core's regA/regB/regO outputs and

---
 rtl/core_trace_fifo.sv | 133 +++++++++++++
 1 files changed

// File: rtl/core_trace_fifo.sv
// Trace observer for the 4-bit core: snapshots {regA,regB,regO} on every regO change
// into a first-word-fall-through FIFO drained over valid/ready, counting lost snapshots.
module core_trace_fifo #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       regA_i,
  input  logic [DATA_W-1:0]       regB_i,
  input  logic [DATA_W-1:0]       regO_i,
  input  logic                    capture_en,
  input  logic                    clear_ovf,
  output logic [3*DATA_W-1:0]     trace_data,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned OCC_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 3 * DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [DATA_W-1:0]    prev_o;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0]   mem [DEPTH];

  logic                 event_c;
  logic                 pop_c;
  logic                 push_c;
  logic                 drop_c;
  logic                 full_c;
  logic [ENTRY_W-1:0]   snap_c;
  logic [OCC_W-1:0]     count_next;
  logic [ENTRY_W-1:0]   data_next;

  // Tracing FSM: PRIME emits one baseline snapshot, RUN emits on regO change.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    event_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (capture_en) state_next = PRIME;
      end
      PRIME: begin
        if (capture_en) begin
          event_c    = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (capture_en) event_c = (regO_i != prev_o);
        else            state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign snap_c = {regA_i, regB_i, regO_i};
  assign full_c = (count == OCC_W'(DEPTH));
  assign pop_c  = trace_valid && trace_ready;
  assign push_c = event_c && (!full_c || pop_c);
  assign drop_c = event_c && !push_c;

  // Occupancy and the registered head word seen by the consumer.
  always_comb begin
    count_next = count;
    if (push_c && !pop_c)      count_next = count + OCC_W'(1);
    else if (pop_c && !push_c) count_next = count - OCC_W'(1);

    data_next = trace_data;
    if (push_c && (count == '0 || (count == OCC_W'(1) && pop_c)))
      data_next = snap_c;
    else if (pop_c && count > OCC_W'(1))
      data_next = mem[rd_ptr + PTR_W'(1)];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_o      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      trace_valid <= 1'b0;
      trace_data  <= '0;
    end else begin
      // A dropped snapshot still advances the change reference, so it is never retried.
      if (event_c) prev_o <= regO_i;
      if (push_c)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)   rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_next;
      trace_valid <= (count_next != '0);
      trace_data  <= data_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= snap_c;
  end

  // Loss accounting: a same-cycle drop overrides clear_ovf.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop_c) begin
      overflow <= 1'b1;
      if (clear_ovf)                      drop_cnt <= CNT_W'(1);
      else if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
    end else if (clear_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule
